// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array and its tile schedulers.
package systolic_pkg;

  localparam int DEF_ROWS   = 4;
  localparam int DEF_COLS   = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_K_W    = 8;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN,
    DONE
  } sched_state_t;

endpackage

// File: rtl/skew_lane_ctr.sv
// One edge lane: beat counter plus skew-gated valid.
// Lane 0 gets k_len as its predecessor so only the k_len bound applies.
module skew_lane_ctr
  import systolic_pkg::*;
#(
  parameter int KW = DEF_K_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          feed_en,
  input  logic          ready,
  input  logic [KW-1:0] pred_cnt,
  input  logic [KW-1:0] k_len,
  output logic          valid,
  output logic [KW-1:0] cnt
);

  logic [KW-1:0] r_cnt;
  logic          w_valid;

  assign w_valid = feed_en
                && (r_cnt < k_len)
                && (r_cnt < pred_cnt);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (w_valid && ready) begin
      r_cnt <= r_cnt + KW'(1);
    end
  end

  assign valid = w_valid;
  assign cnt   = r_cnt;

endmodule

// File: rtl/systolic_tile_sched.sv
// Tile sequencer: skewed operand feed into the array edges,
// then counts corner results and pulses done.
module systolic_tile_sched
  import systolic_pkg::*;
#(
  parameter int ROWS   = DEF_ROWS,
  parameter int COLS   = DEF_COLS,
  parameter int DATA_W = DEF_DATA_W,
  parameter int K_W    = DEF_K_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [K_W-1:0]         k_len,
  output logic                   busy,
  output logic                   done,
  output logic [ROWS*K_W-1:0]    a_rd_addr,
  input  logic [ROWS*DATA_W-1:0] a_rd_data,
  output logic [COLS*K_W-1:0]    b_rd_addr,
  input  logic [COLS*DATA_W-1:0] b_rd_data,
  output logic [ROWS*DATA_W-1:0] a_edge,
  output logic [ROWS-1:0]        a_edge_valid,
  input  logic [ROWS-1:0]        a_edge_ready,
  output logic [COLS*DATA_W-1:0] b_edge,
  output logic [COLS-1:0]        b_edge_valid,
  input  logic [COLS-1:0]        b_edge_ready,
  input  logic                   corner_fire
);

  localparam logic [K_W-1:0] ONE = K_W'(1);

  sched_state_t   r_state;
  logic [K_W-1:0] r_klen;
  logic [K_W-1:0] r_nc;
  logic           r_busy;
  logic           r_done;

  logic           w_clr;
  logic           w_feed;
  logic           w_all_done;
  logic           w_fire_ok;
  logic           w_nc_last;
  logic [K_W-1:0] w_ia     [ROWS];
  logic [K_W-1:0] w_ib     [COLS];
  logic [K_W-1:0] w_a_pred [ROWS];
  logic [K_W-1:0] w_b_pred [COLS];
  logic [ROWS-1:0] w_a_done;
  logic [COLS-1:0] w_b_done;

  assign w_clr  = (r_state == IDLE) && start;
  assign w_feed = (r_state == FEED);

  assign w_a_pred[0] = r_klen;
  assign w_b_pred[0] = r_klen;

  for (genvar i = 0; i < ROWS; i++) begin : g_a
    if (i > 0) begin : g_pred
      assign w_a_pred[i] = w_ia[i-1];
    end
    skew_lane_ctr #(.KW(K_W)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .clr      (w_clr),
      .feed_en  (w_feed),
      .ready    (a_edge_ready[i]),
      .pred_cnt (w_a_pred[i]),
      .k_len    (r_klen),
      .valid    (a_edge_valid[i]),
      .cnt      (w_ia[i])
    );
    assign a_rd_addr[i*K_W +: K_W] = w_ia[i];
    assign w_a_done[i] = (w_ia[i] == r_klen);
  end

  for (genvar j = 0; j < COLS; j++) begin : g_b
    if (j > 0) begin : g_pred
      assign w_b_pred[j] = w_ib[j-1];
    end
    skew_lane_ctr #(.KW(K_W)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .clr      (w_clr),
      .feed_en  (w_feed),
      .ready    (b_edge_ready[j]),
      .pred_cnt (w_b_pred[j]),
      .k_len    (r_klen),
      .valid    (b_edge_valid[j]),
      .cnt      (w_ib[j])
    );
    assign b_rd_addr[j*K_W +: K_W] = w_ib[j];
    assign w_b_done[j] = (w_ib[j] == r_klen);
  end

  assign a_edge = a_rd_data;
  assign b_edge = b_rd_data;

  assign w_all_done = (&w_a_done) && (&w_b_done);
  assign w_fire_ok  = corner_fire && (r_nc < r_klen);
  // A fire landing on the final count finishes the tile this cycle.
  assign w_nc_last  = (r_nc == r_klen)
                   || (w_fire_ok && ((r_nc + ONE) == r_klen));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_klen  <= '0;
      r_nc    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_klen <= k_len;
            r_nc   <= '0;
            if (k_len != '0) begin
              r_state <= FEED;
              r_busy  <= 1'b1;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        FEED: begin
          if (w_fire_ok) r_nc <= r_nc + ONE;
          if (abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (w_all_done) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_fire_ok) r_nc <= r_nc + ONE;
          if (abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (w_nc_last) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_systolic_tile_sched.sv
// Directed bench for systolic_tile_sched: skewed feed, stalls,
// zero-length tiles, abort, start-while-busy and mid-tile reset.
module tb_systolic_tile_sched;

  localparam int R  = 4;
  localparam int C  = 4;
  localparam int DW = 8;
  localparam int KW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            abort;
  logic [KW-1:0]   k_len;
  logic            busy;
  logic            done;
  logic [R*KW-1:0] a_rd_addr;
  logic [R*DW-1:0] a_rd_data;
  logic [C*KW-1:0] b_rd_addr;
  logic [C*DW-1:0] b_rd_data;
  logic [R*DW-1:0] a_edge;
  logic [R-1:0]    a_edge_valid;
  logic [R-1:0]    a_edge_ready;
  logic [C*DW-1:0] b_edge;
  logic [C-1:0]    b_edge_valid;
  logic [C-1:0]    b_edge_ready;
  logic            corner_fire;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int a_log [R][16];
  int b_log [C][16];
  int a_n [R];
  int b_n [C];
  int a_first [R];
  int skew_viol;
  int done_cnt;
  bit valid_seen;

  always #5 clk = ~clk;

  systolic_tile_sched #(
    .ROWS(R), .COLS(C), .DATA_W(DW), .K_W(KW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .k_len        (k_len),
    .busy         (busy),
    .done         (done),
    .a_rd_addr    (a_rd_addr),
    .a_rd_data    (a_rd_data),
    .b_rd_addr    (b_rd_addr),
    .b_rd_data    (b_rd_data),
    .a_edge       (a_edge),
    .a_edge_valid (a_edge_valid),
    .a_edge_ready (a_edge_ready),
    .b_edge       (b_edge),
    .b_edge_valid (b_edge_valid),
    .b_edge_ready (b_edge_ready),
    .corner_fire  (corner_fire)
  );

  // Register-file model: row i holds i*16+addr, column j holds 128+j*16+addr.
  always_comb begin
    for (int i = 0; i < R; i++)
      a_rd_data[i*DW +: DW] = DW'(i*16) + a_rd_addr[i*KW +: KW];
    for (int j = 0; j < C; j++)
      b_rd_data[j*DW +: DW] = DW'(128 + j*16) + b_rd_addr[j*KW +: KW];
  end

  // Transfer monitor, sampled 1 time unit before each rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      cyc++;
      for (int i = 0; i < R; i++) begin
        if (a_edge_valid[i] && a_edge_ready[i]) begin
          if (a_n[i] == 0) a_first[i] = cyc;
          if (a_n[i] < 16) a_log[i][a_n[i]] = int'(a_rd_addr[i*KW +: KW]);
          a_n[i]++;
        end
      end
      for (int j = 0; j < C; j++) begin
        if (b_edge_valid[j] && b_edge_ready[j]) begin
          if (b_n[j] < 16) b_log[j][b_n[j]] = int'(b_rd_addr[j*KW +: KW]);
          b_n[j]++;
        end
      end
      for (int i = 1; i < R; i++)
        if (a_rd_addr[i*KW +: KW] > a_rd_addr[(i-1)*KW +: KW]) skew_viol++;
      for (int j = 1; j < C; j++)
        if (b_rd_addr[j*KW +: KW] > b_rd_addr[(j-1)*KW +: KW]) skew_viol++;
      if (a_edge_valid != '0 || b_edge_valid != '0) valid_seen = 1'b1;
      if (done) done_cnt++;
    end
  end

  task automatic clear_logs();
    for (int i = 0; i < R; i++) begin
      a_n[i] = 0;
      a_first[i] = -1;
    end
    for (int j = 0; j < C; j++) b_n[j] = 0;
    skew_viol  = 0;
    done_cnt   = 0;
    valid_seen = 1'b0;
  endtask

  function automatic bit seq_ok(input bit is_a, input int lane, input int k);
    int n;
    n = is_a ? a_n[lane] : b_n[lane];
    if (n != k) return 1'b0;
    for (int x = 0; x < k; x++) begin
      if (is_a && a_log[lane][x] != x) return 1'b0;
      if (!is_a && b_log[lane][x] != x) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Returns at the negedge following the accepting edge.
  task automatic start_tile(input logic [KW-1:0] k);
    @(negedge clk);
    start = 1'b1;
    k_len = k;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_feed_end(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (a_edge_valid == '0 && b_edge_valid == '0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic fire_corner(input int n);
    for (int f = 0; f < n; f++) begin
      corner_fire = 1'b1;
      @(negedge clk);
    end
    corner_fire = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    k_len = '0;
    corner_fire = 1'b0;
    a_edge_ready = '1;
    b_edge_ready = '1;
    clear_logs();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags busy=%b done=%b exp 0/0", busy, done);
    end
    checks++;
    if (a_edge_valid !== '0 || b_edge_valid !== '0) begin
      errors++;
      $display("FAIL reset_valid a=%b b=%b exp 0", a_edge_valid, b_edge_valid);
    end
    checks++;
    if (a_rd_addr !== '0 || b_rd_addr !== '0) begin
      errors++;
      $display("FAIL reset_addr a=%h b=%h exp 0", a_rd_addr, b_rd_addr);
    end
  endtask

  task automatic test_basic_k3();
    bit ok;
    bit good;
    clear_logs();
    start_tile(8'd3);
    checks++;
    if (a_edge_valid !== 4'b0001 || b_edge_valid !== 4'b0001 || busy !== 1'b1) begin
      errors++;
      $display("FAIL k3_first_valid a=%b b=%b busy=%b exp 0001/0001/1",
               a_edge_valid, b_edge_valid, busy);
    end
    checks++;
    if (a_edge[7:0] !== 8'h00 || b_edge[7:0] !== 8'h80) begin
      errors++;
      $display("FAIL k3_edge_data a0=%h b0=%h exp 00/80", a_edge[7:0], b_edge[7:0]);
    end
    @(negedge clk);
    checks++;
    if (a_edge_valid !== 4'b0011 || a_edge[15:8] !== 8'h10) begin
      errors++;
      $display("FAIL k3_second_cycle valid=%b a1=%h exp 0011/10",
               a_edge_valid, a_edge[15:8]);
    end
    wait_feed_end(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL k3_feed_timeout valids=%b/%b exp 0", a_edge_valid, b_edge_valid);
    end
    fire_corner(2);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL k3_two_fires done=%b busy=%b exp 0/1", done, busy);
    end
    fire_corner(1);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL k3_done done=%b busy=%b exp 1/0", done, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || done_cnt != 1) begin
      errors++;
      $display("FAIL k3_done_pulse done=%b cnt=%0d exp 0/1", done, done_cnt);
    end
    good = 1'b1;
    for (int i = 0; i < R; i++) if (!seq_ok(1'b1, i, 3)) good = 1'b0;
    for (int j = 0; j < C; j++) if (!seq_ok(1'b0, j, 3)) good = 1'b0;
    checks++;
    if (!good) begin
      errors++;
      $display("FAIL k3_addr_seq a_n=%0d,%0d,%0d,%0d exp 3 each seq 0..2",
               a_n[0], a_n[1], a_n[2], a_n[3]);
    end
    good = 1'b1;
    for (int i = 1; i < R; i++) if (a_first[i] - a_first[0] != i) good = 1'b0;
    checks++;
    if (!good || skew_viol != 0) begin
      errors++;
      $display("FAIL k3_skew first=%0d,%0d,%0d,%0d viol=%0d exp offsets 0..3 viol 0",
               a_first[0], a_first[1], a_first[2], a_first[3], skew_viol);
    end
  endtask

  task automatic test_stall();
    bit ok;
    bit good;
    clear_logs();
    start_tile(8'd6);
    repeat (2) @(negedge clk);
    a_edge_ready[0] = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (a_edge_valid !== 4'b0001 || a_rd_addr !== {4{8'd2}}) begin
      errors++;
      $display("FAIL stall_hold valid=%b addr=%h exp 0001/02020202",
               a_edge_valid, a_rd_addr);
    end
    a_edge_ready[0] = 1'b1;
    wait_feed_end(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_feed_timeout valids=%b/%b exp 0", a_edge_valid, b_edge_valid);
    end
    fire_corner(6);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL stall_done done=%b exp 1", done);
    end
    good = 1'b1;
    for (int i = 0; i < R; i++) if (!seq_ok(1'b1, i, 6)) good = 1'b0;
    for (int j = 0; j < C; j++) if (!seq_ok(1'b0, j, 6)) good = 1'b0;
    checks++;
    if (!good || skew_viol != 0) begin
      errors++;
      $display("FAIL stall_seq a_n=%0d,%0d,%0d,%0d viol=%0d exp 6 each viol 0",
               a_n[0], a_n[1], a_n[2], a_n[3], skew_viol);
    end
  endtask

  task automatic test_zero_len();
    clear_logs();
    start_tile(8'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_done done=%b busy=%b exp 1/0", done, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || valid_seen !== 1'b0 || a_rd_addr !== '0) begin
      errors++;
      $display("FAIL zero_quiet done=%b valid_seen=%b addr=%h exp 0/0/0",
               done, valid_seen, a_rd_addr);
    end
  endtask

  task automatic test_abort();
    bit ok;
    bit good;
    clear_logs();
    start_tile(8'd8);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || a_edge_valid !== '0 || b_edge_valid !== '0) begin
      errors++;
      $display("FAIL abort_idle busy=%b a=%b b=%b exp 0/0/0",
               busy, a_edge_valid, b_edge_valid);
    end
    checks++;
    if (a_rd_addr !== {8'd0, 8'd0, 8'd1, 8'd2}) begin
      errors++;
      $display("FAIL abort_beats addr=%h exp 00000102", a_rd_addr);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt != 0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done cnt=%0d exp 0", done_cnt);
    end
    clear_logs();
    start_tile(8'd2);
    wait_feed_end(ok);
    fire_corner(2);
    checks++;
    if (!ok || done !== 1'b1) begin
      errors++;
      $display("FAIL abort_restart feed_ok=%b done=%b exp 1/1", ok, done);
    end
    good = 1'b1;
    for (int i = 0; i < R; i++) if (!seq_ok(1'b1, i, 2)) good = 1'b0;
    for (int j = 0; j < C; j++) if (!seq_ok(1'b0, j, 2)) good = 1'b0;
    checks++;
    if (!good) begin
      errors++;
      $display("FAIL abort_restart_seq a_n=%0d,%0d,%0d,%0d exp 2 each",
               a_n[0], a_n[1], a_n[2], a_n[3]);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    start_tile(8'd2);
    start = 1'b1;
    k_len = 8'd5;
    @(negedge clk);
    start = 1'b0;
    wait_feed_end(ok);
    checks++;
    if (!ok || a_rd_addr !== {4{8'd2}} || b_rd_addr !== {4{8'd2}}) begin
      errors++;
      $display("FAIL busy_start_ignored ok=%b a=%h b=%h exp 02020202",
               ok, a_rd_addr, b_rd_addr);
    end
    repeat (2) @(negedge clk);
    fire_corner(1);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL drain_partial done=%b busy=%b exp 0/1", done, busy);
    end
    @(negedge clk);
    fire_corner(1);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drain_coincident done=%b busy=%b exp 1/0", done, busy);
    end
  endtask

  task automatic test_rst_drain();
    bit ok;
    start_tile(8'd2);
    wait_feed_end(ok);
    repeat (2) @(negedge clk);
    fire_corner(1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || a_edge_valid !== '0 || b_edge_valid !== '0) begin
      errors++;
      $display("FAIL rst_drain_flags busy=%b done=%b a=%b b=%b exp 0",
               busy, done, a_edge_valid, b_edge_valid);
    end
    checks++;
    if (a_rd_addr !== '0 || b_rd_addr !== '0) begin
      errors++;
      $display("FAIL rst_drain_addr a=%h b=%h exp 0", a_rd_addr, b_rd_addr);
    end
    start_tile(8'd1);
    wait_feed_end(ok);
    @(negedge clk);
    fire_corner(1);
    checks++;
    if (!ok || done !== 1'b1) begin
      errors++;
      $display("FAIL rst_restart ok=%b done=%b exp 1/1", ok, done);
    end
  endtask

  initial begin
    test_reset();
    test_basic_k3();
    test_stall();
    test_zero_len();
    test_abort();
    test_back_to_back();
    test_rst_drain();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
